// File: rtl/div_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : div_seq_pkg                                            |
// | Description : Shared divider state encodings and status constants,  |
// |               also used by the datapath and hazard unit.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package div_seq_pkg;

   // Divider FSM state encodings
   localparam int unsigned c_state_w     = 2;
   localparam logic [1:0]  c_div_idle    = 2'b00;
   localparam logic [1:0]  c_div_divzero = 2'b01;
   localparam logic [1:0]  c_div_on      = 2'b10;
   localparam logic [1:0]  c_div_end     = 2'b11;

   // Result-status constants seen by the pipeline
   localparam logic c_div_result_ready     = 1'b1;
   localparam logic c_div_result_not_ready = 1'b0;

   // Iteration counter width (counts 0..31 for a 32-bit datapath)
   localparam int unsigned c_cnt_w = 6;

   // Counter value of the final restoring step for a given operand width
   function automatic logic [c_cnt_w-1:0] last_iter(input int unsigned width);
      return c_cnt_w'(width - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : div_step                                               |
// | Description : One combinational restoring-division step. Takes the  |
// |               shifted partial remainder and the divisor magnitude,   |
// |               returns the next remainder and one quotient bit.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   partial,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             quo_bit
);

   logic [WIDTH:0] w_diff;

   // Trial subtract; keep the difference only when it did not go negative.
   // The partial remainder is always below twice the divisor, so WIDTH+1
   // bits are enough for the sign of the difference to be meaningful.
   always_comb begin
      w_diff   = partial - {1'b0, divisor};
      quo_bit  = ~w_diff[WIDTH];
      rem_next = quo_bit ? w_diff[WIDTH-1:0] : partial[WIDTH-1:0];
   end

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : div_seq                                                |
// | Description : Sequential restoring divider for DIV/DIVU. One step   |
// |               per cycle, magnitudes divided, signs fixed in END.     |
// |               result_o = {remainder, quotient} for HI/LO.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic               annul_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   logic [c_state_w-1:0] r_state;
   logic [c_state_w-1:0] w_state_next;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_quo;     // dividend magnitude, shifted out as quotient shifts in
   logic [WIDTH-1:0]     r_dvs;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic [2*WIDTH-1:0]   r_result;

   logic                 w_accept;
   logic                 w_last;
   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [WIDTH-1:0]     w_rem_next;
   logic                 w_qbit;
   logic [WIDTH-1:0]     w_q_fix;
   logic [WIDTH-1:0]     w_r_fix;
   logic [2*WIDTH-1:0]   w_final;

   assign w_accept = (r_state == c_div_idle) && start_i && !annul_i;
   assign w_last   = (r_cnt == last_iter(WIDTH));

   // Two's-complement magnitudes for signed requests; the most negative
   // value maps onto itself, which is its correct unsigned magnitude
   assign w_abs_a  = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign w_abs_b  = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

   // Sign correction of the finished magnitudes
   assign w_q_fix  = r_neg_q ? -r_quo : r_quo;
   assign w_r_fix  = r_neg_r ? -r_rem : r_rem;
   assign w_final  = {w_r_fix, w_q_fix};

   div_step #(
      .WIDTH    (WIDTH)
   ) u_div_step (
      .partial  ({r_rem, r_quo[WIDTH-1]}),
      .divisor  (r_dvs),
      .rem_next (w_rem_next),
      .quo_bit  (w_qbit)
   );

   // State register; reset wins over any request or annul
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_div_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_div_idle: begin
            if (w_accept) begin
               w_state_next = (opdata2_i == '0) ? c_div_divzero : c_div_on;
            end
         end
         c_div_divzero: begin
            w_state_next = annul_i ? c_div_idle : c_div_end;
         end
         c_div_on: begin
            if (annul_i) begin
               w_state_next = c_div_idle;
            end else if (w_last) begin
               w_state_next = c_div_end;
            end
         end
         c_div_end: begin
            w_state_next = c_div_idle;
         end
         default: begin
            w_state_next = c_div_idle;
         end
      endcase
   end

   // Outputs: stall request, one-cycle ready pulse, result held between ENDs
   always_comb begin
      busy_o   = !rst && (w_accept || (r_state == c_div_on) || (r_state == c_div_divzero));
      ready_o  = (!rst && (r_state == c_div_end)) ? c_div_result_ready : c_div_result_not_ready;
      result_o = (r_state == c_div_end) ? w_final : r_result;
   end

   // Datapath: latch operands on accept, iterate in ON, capture result in END
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            c_div_idle: begin
               if (w_accept) begin
                  r_cnt   <= '0;
                  r_rem   <= '0;
                  r_quo   <= w_abs_a;
                  r_dvs   <= w_abs_b;
                  r_neg_q <= signed_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  r_neg_r <= signed_i && opdata1_i[WIDTH-1];
               end
            end
            c_div_divzero: begin
               r_rem <= '0;
               r_quo <= '0;
            end
            c_div_on: begin
               r_rem <= w_rem_next;
               r_quo <= {r_quo[WIDTH-2:0], w_qbit};
               r_cnt <= r_cnt + 1'b1;
            end
            c_div_end: begin
               r_result <= w_final;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_div_seq                                             |
// | Description : Directed self-checking bench for div_seq.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic        signed_i;
   logic        annul_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        busy_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div_seq #(
      .WIDTH     (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .signed_i  (signed_i),
      .annul_i   (annul_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .result_o  (result_o),
      .ready_o   (ready_o),
      .busy_o    (busy_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Issue one request, then scramble the inputs and follow it cycle by cycle
   task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input logic [63:0] exp, input int lat,
                         input logic annul_end);
      logic [63:0] prev;
      prev = result_o;
      @(posedge clk); #1;
      start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b; annul_i = 1'b0;
      #4;
      chk1({tag, " busy@0"}, busy_o, 1'b1);
      chk1({tag, " ready@0"}, ready_o, 1'b0);
      for (int k = 1; k <= lat + 1; k++) begin
         @(posedge clk); #1;
         start_i   = 1'b0;
         signed_i  = ~sgn;
         opdata1_i = $urandom;
         opdata2_i = $urandom;
         annul_i   = annul_end && (k == lat);
         #4;
         chk1($sformatf("%s ready@%0d", tag, k), ready_o, k == lat);
         chk1($sformatf("%s busy@%0d", tag, k), busy_o, k < lat);
         if (k < lat)  chk($sformatf("%s held@%0d", tag, k), result_o, prev);
         if (k == lat) chk({tag, " result"}, result_o, exp);
         if (k > lat)  chk({tag, " result kept"}, result_o, exp);
      end
      annul_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] prev;

      // Reset with a request pending: reset must win and hold busy low
      rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0;
      opdata1_i = 32'd5; opdata2_i = 32'd1;
      repeat (2) @(posedge clk);
      #5;
      chk("reset result", result_o, 64'h0);
      chk1("reset ready", ready_o, 1'b0);
      chk1("reset busy", busy_o, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; start_i = 1'b0;

      // Main function
      do_div("u100/7",  32'd100,        32'd7,        1'b0, 64'h00000002_0000000E, 33, 1'b0);
      do_div("s-7/2",   32'hFFFFFFF9,   32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 1'b1);
      do_div("u-7/2",   32'hFFFFFFF9,   32'h00000002, 1'b0, 64'h00000001_7FFFFFFC, 33, 1'b0);
      do_div("smin/-1", 32'h80000000,   32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 1'b0);
      do_div("umin/-1", 32'h80000000,   32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 33, 1'b0);
      do_div("s/0",     32'd12345,      32'd0,        1'b1, 64'h0,                  2, 1'b0);
      do_div("u-1/3",   32'hFFFFFFFF,   32'd3,        1'b0, 64'h00000000_55555555, 33, 1'b0);
      do_div("u/0",     32'hFFFFFFF9,   32'd0,        1'b0, 64'h0,                  2, 1'b0);

      // Annul during iteration 10
      do_div("u17/5",   32'd17,         32'd5,        1'b0, 64'h00000002_00000003, 33, 1'b0);
      prev = result_o;
      @(posedge clk); #1;
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         annul_i = (k == 11);
      end
      #4;
      chk1("annul busy in ON", busy_o, 1'b1);
      @(posedge clk); #1;
      annul_i = 1'b0;
      #4;
      chk1("annul busy after", busy_o, 1'b0);
      chk1("annul ready after", ready_o, 1'b0);
      chk("annul result kept", result_o, prev);
      for (int k = 0; k < 34; k++) begin
         @(negedge clk);
         chk1($sformatf("annul no ready@%0d", k), ready_o, 1'b0);
      end
      do_div("u9/3",    32'd9,          32'd3,        1'b0, 64'h00000000_00000003, 33, 1'b0);

      // Reset at iteration 20, with start and annul also high
      @(posedge clk); #1;
      start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
      for (int k = 1; k <= 21; k++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         if (k == 21) begin
            rst = 1'b1; start_i = 1'b1; annul_i = 1'b1;
         end
      end
      @(posedge clk); #1;
      annul_i = 1'b0;
      #4;
      chk1("rst busy", busy_o, 1'b0);
      chk1("rst ready", ready_o, 1'b0);
      chk("rst result", result_o, 64'h0);
      @(posedge clk); #1;
      rst = 1'b0; start_i = 1'b0;
      for (int k = 0; k < 36; k++) begin
         @(negedge clk);
         chk1($sformatf("rst no ready@%0d", k), ready_o, 1'b0);
      end
      chk("rst result final", result_o, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
